// File: rtl/fp_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fp_align_pipe
//  Purpose  : Two-stage floating-point operand alignment pipeline. Picks the
//             operand with the larger effective exponent, and right-shifts the
//             other operand's mantissa by the exponent difference. Bits shifted
//             out are folded into a sticky bit.
//  Ports    : clk, rst_n          - clock, async active-low reset
//             in_valid/in_ready   - operand handshake
//             op_a, op_b          - {sign, exponent, fraction} operands
//             out_valid/out_ready - result handshake
//             out_exp             - common (larger effective) exponent
//             out_man_l/out_man_s - larger / aligned smaller mantissa (GRS)
//             out_sign_l/_s       - signs of larger / smaller operand
//             out_swap            - B was the larger operand
//             out_shamt           - applied exponent difference
//             out_special         - an operand has an all-ones exponent
//  Revision : 1.0  initial release
// ============================================================================
module fp_align_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   op_a,
  input  logic [EXP_W+MAN_W:0]   op_b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W-1:0]       out_exp,
  output logic [MAN_W+3:0]       out_man_l,
  output logic [MAN_W+3:0]       out_man_s,
  output logic                   out_sign_l,
  output logic                   out_sign_s,
  output logic                   out_swap,
  output logic [EXP_W-1:0]       out_shamt,
  output logic                   out_special
);

  localparam int          c_w = 1 + EXP_W + MAN_W;
  localparam int          c_m = MAN_W + 4;
  localparam logic [31:0] c_m_u = 32'(c_m);

  // --------------------------------------------------------------------------
  // Handshake: each stage advances when it is empty or its consumer takes data
  // --------------------------------------------------------------------------
  logic r_s1_valid, r_s2_valid;
  logic w_s2_adv, w_s1_adv;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  // --------------------------------------------------------------------------
  // Stage-1 combinational decode and compare
  // --------------------------------------------------------------------------
  logic [EXP_W-1:0] w_exp_a, w_exp_b, w_eff_a, w_eff_b;
  logic [c_m-1:0]   w_man_a, w_man_b;
  logic             w_a_ge, w_special;
  logic [EXP_W-1:0] w_diff;

  assign w_exp_a = op_a[c_w-2:MAN_W];
  assign w_exp_b = op_b[c_w-2:MAN_W];

  // Denormals (exponent field 0) behave as exponent 1 with no hidden bit.
  assign w_eff_a = (w_exp_a == '0) ? EXP_W'(1) : w_exp_a;
  assign w_eff_b = (w_exp_b == '0) ? EXP_W'(1) : w_exp_b;
  assign w_man_a = {|w_exp_a, op_a[MAN_W-1:0], 3'b000};
  assign w_man_b = {|w_exp_b, op_b[MAN_W-1:0], 3'b000};

  assign w_a_ge    = (w_eff_a >= w_eff_b);
  assign w_special = (&w_exp_a) || (&w_exp_b);
  // Inf/NaN operands are passed through unshifted.
  assign w_diff    = w_special ? '0 :
                     (w_a_ge ? (w_eff_a - w_eff_b) : (w_eff_b - w_eff_a));

  logic             r_s1_sign_l, r_s1_sign_s, r_s1_swap, r_s1_special;
  logic [EXP_W-1:0] r_s1_exp, r_s1_shamt;
  logic [c_m-1:0]   r_s1_man_l, r_s1_man_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_sign_l  <= 1'b0;
      r_s1_sign_s  <= 1'b0;
      r_s1_swap    <= 1'b0;
      r_s1_special <= 1'b0;
      r_s1_exp     <= '0;
      r_s1_shamt   <= '0;
      r_s1_man_l   <= '0;
      r_s1_man_s   <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_swap    <= !w_a_ge;
        r_s1_special <= w_special;
        r_s1_shamt   <= w_diff;
        r_s1_exp     <= w_a_ge ? w_eff_a : w_eff_b;
        r_s1_sign_l  <= w_a_ge ? op_a[c_w-1] : op_b[c_w-1];
        r_s1_sign_s  <= w_a_ge ? op_b[c_w-1] : op_a[c_w-1];
        r_s1_man_l   <= w_a_ge ? w_man_a : w_man_b;
        r_s1_man_s   <= w_a_ge ? w_man_b : w_man_a;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage-2 combinational sticky right shift
  // --------------------------------------------------------------------------
  logic [c_m-1:0] w_shifted, w_mask, w_man_s_sh;
  logic           w_lost, w_big;

  assign w_shifted = r_s1_man_s >> r_s1_shamt;
  assign w_mask    = ~({c_m{1'b1}} << r_s1_shamt);   // bits that fall off
  assign w_lost    = |(r_s1_man_s & w_mask);
  assign w_big     = (32'(r_s1_shamt) >= c_m_u);
  assign w_man_s_sh = w_big ? {{(c_m-1){1'b0}}, |r_s1_man_s}
                            : {w_shifted[c_m-1:1], w_shifted[0] | w_lost};

  logic             r_s2_sign_l, r_s2_sign_s, r_s2_swap, r_s2_special;
  logic [EXP_W-1:0] r_s2_exp, r_s2_shamt;
  logic [c_m-1:0]   r_s2_man_l, r_s2_man_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_sign_l  <= 1'b0;
      r_s2_sign_s  <= 1'b0;
      r_s2_swap    <= 1'b0;
      r_s2_special <= 1'b0;
      r_s2_exp     <= '0;
      r_s2_shamt   <= '0;
      r_s2_man_l   <= '0;
      r_s2_man_s   <= '0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_sign_l  <= r_s1_sign_l;
        r_s2_sign_s  <= r_s1_sign_s;
        r_s2_swap    <= r_s1_swap;
        r_s2_special <= r_s1_special;
        r_s2_exp     <= r_s1_exp;
        r_s2_shamt   <= r_s1_shamt;
        r_s2_man_l   <= r_s1_man_l;
        r_s2_man_s   <= w_man_s_sh;
      end
    end
  end

  assign out_valid   = r_s2_valid;
  assign out_exp     = r_s2_exp;
  assign out_man_l   = r_s2_man_l;
  assign out_man_s   = r_s2_man_s;
  assign out_sign_l  = r_s2_sign_l;
  assign out_sign_s  = r_s2_sign_s;
  assign out_swap    = r_s2_swap;
  assign out_shamt   = r_s2_shamt;
  assign out_special = r_s2_special;

endmodule
`default_nettype wire

// File: tb/tb_fp_align_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_align_pipe
//  Purpose  : Self-checking bench for fp_align_pipe. Directed operand pairs
//             with hand-computed results feed a scoreboard queue; a monitor
//             pops and compares on every output transfer and checks that
//             outputs hold while stalled.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_align_pipe;

  typedef struct packed {
    logic [7:0]  exp;
    logic [26:0] man_l;
    logic [26:0] man_s;
    logic        sign_l;
    logic        sign_s;
    logic        swap;
    logic [7:0]  shamt;
    logic        special;
  } res_t;

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_a, op_b;
  logic [7:0]  out_exp, out_shamt;
  logic [26:0] out_man_l, out_man_s;
  logic        out_sign_l, out_sign_s, out_swap, out_special;

  fp_align_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_exp    (out_exp),
    .out_man_l  (out_man_l),
    .out_man_s  (out_man_s),
    .out_sign_l (out_sign_l),
    .out_sign_s (out_sign_s),
    .out_swap   (out_swap),
    .out_shamt  (out_shamt),
    .out_special(out_special)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  res_t sb_q[$];
  res_t cur, held;
  logic stall_prev = 1'b0;

  assign cur = {out_exp, out_man_l, out_man_s, out_sign_l, out_sign_s,
                out_swap, out_shamt, out_special};

  function automatic res_t mk(input logic [7:0] e, input logic [26:0] ml,
                              input logic [26:0] ms, input logic sl,
                              input logic ss, input logic sw,
                              input logic [7:0] sh, input logic sp);
    mk = {e, ml, ms, sl, ss, sw, sh, sp};
  endfunction

  task automatic check1(input string name, input logic [31:0] act,
                        input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: compare each transferred result against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (stall_prev && out_valid) begin
        checks++;
        if (cur !== held) begin
          errors++;
          $display("FAIL stall_hold: got %h, required %h", cur, held);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got %h, required none", cur);
        end else begin
          res_t e;
          e = sb_q.pop_front();
          if (cur !== e) begin
            errors++;
            $display("FAIL result: got %h, required %h", cur, e);
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      held       = cur;
    end else begin
      stall_prev = 1'b0;
    end
  end

  // Drive one operand pair; returns just after the accepting clock edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b,
                      input res_t e);
    int budget;
    @(negedge clk);
    op_a = a;
    op_b = b;
    in_valid = 1'b1;
    sb_q.push_back(e);
    #1;
    budget = 200;
    while (!in_ready && budget > 0) begin
      @(negedge clk);
      #1;
      budget--;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: got in_ready=0, required 1");
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
  endtask

  initial begin
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op_a      = '0;
    op_b      = '0;
    rst_n     = 1'b1;
    #1 rst_n  = 1'b0;
    #2;
    check1("reset_out_valid", 32'(out_valid), 32'd0);
    check1("reset_in_ready", 32'(in_ready), 32'd1);
    check1("reset_out_man_l", 32'(out_man_l), 32'd0);
    #20 rst_n = 1'b1;

    // Basic alignment cases
    send(32'h3F800000, 32'h3F000000, mk(8'h7F, 27'h4000000, 27'h2000000, 0, 0, 0, 8'd1, 0));
    send(32'h3F000000, 32'h40000000, mk(8'h80, 27'h4000000, 27'h1000000, 0, 0, 1, 8'd2, 0));
    send(32'h4B800000, 32'h3F800001, mk(8'h97, 27'h4000000, 27'h0000005, 0, 0, 0, 8'd24, 0));
    send(32'h7E800000, 32'hBF800000, mk(8'hFD, 27'h4000000, 27'h0000001, 0, 1, 0, 8'd126, 0));
    // Specials: A Inf, then B NaN with sign
    send(32'h7F800000, 32'h3F800000, mk(8'hFF, 27'h4000000, 27'h4000000, 0, 0, 0, 8'd0, 1));
    send(32'h3F800000, 32'hFF800001, mk(8'hFF, 27'h4000008, 27'h4000000, 1, 0, 1, 8'd0, 1));
    // Equal exponents select A
    send(32'h40400000, 32'hC0000000, mk(8'h80, 27'h6000000, 27'h4000000, 0, 1, 0, 8'd0, 0));
    // Denormals: both denormal, and denormal against smallest normal
    send(32'h00000001, 32'h00400000, mk(8'h01, 27'h0000008, 27'h2000000, 0, 0, 0, 8'd0, 0));
    send(32'h00000000, 32'h00800000, mk(8'h01, 27'h0000000, 27'h4000000, 0, 0, 0, 8'd0, 0));
    // Shift boundary: just below and at the mantissa width
    send(32'h4C000000, 32'h3FC00000, mk(8'h98, 27'h4000000, 27'h0000003, 0, 0, 0, 8'd25, 0));
    send(32'h4D000000, 32'h3FC00000, mk(8'h9A, 27'h4000000, 27'h0000001, 0, 0, 0, 8'd27, 0));

    // Backpressure: three back-to-back with the output stalled
    set_ready(1'b0);
    fork
      begin
        send(32'h3F800000, 32'h3F000000, mk(8'h7F, 27'h4000000, 27'h2000000, 0, 0, 0, 8'd1, 0));
        send(32'h3F000000, 32'h40000000, mk(8'h80, 27'h4000000, 27'h1000000, 0, 0, 1, 8'd2, 0));
        send(32'h4B800000, 32'h3F800001, mk(8'h97, 27'h4000000, 27'h0000005, 0, 0, 0, 8'd24, 0));
      end
      begin
        repeat (6) @(negedge clk);
        #2 check1("stall_in_ready", 32'(in_ready), 32'd0);
        set_ready(1'b1);
      end
    join
    repeat (4) @(negedge clk);

    // Asynchronous reset while a result is held at the output
    set_ready(1'b0);
    send(32'h40400000, 32'hC0000000, mk(8'h80, 27'h6000000, 27'h4000000, 0, 1, 0, 8'd0, 0));
    repeat (3) @(negedge clk);
    check1("pre_reset_out_valid", 32'(out_valid), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check1("async_out_valid", 32'(out_valid), 32'd0);
    check1("async_out_exp", 32'(out_exp), 32'd0);
    check1("async_out_man_s", 32'(out_man_s), 32'd0);
    check1("async_in_ready", 32'(in_ready), 32'd1);
    sb_q.delete();
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    send(32'h3F000000, 32'h40000000, mk(8'h80, 27'h4000000, 27'h1000000, 0, 0, 1, 8'd2, 0));
    @(negedge clk);
    check1("latency_not_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check1("latency_arrive", 32'(out_valid), 32'd1);

    begin
      int budget;
      budget = 100;
      while (sb_q.size() != 0 && budget > 0) begin
        @(negedge clk);
        budget--;
      end
      #1 check1("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
